// File: rtl/conv_collect.sv
// conv_collect: captures one OD x OD convolution frame into block RAM and serves registered reads.
// Optional CONV_COLLECT_RELU_EN clamps negative samples to zero before they are stored.
module conv_collect #(
  parameter int DIM = 32,
  parameter int K   = 5,
  parameter int PP  = 8,
  parameter int AW  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic signed [PP:0]   conv_in,
  input  logic                 in_valid,
  input  logic                 rd_en,
  input  logic [AW-1:0]        rd_addr,
  output logic signed [PP:0]   rd_data,
  output logic                 rd_valid,
  output logic                 busy,
  output logic                 frame_done,
  output logic [AW-1:0]        wr_count,
  output logic                 overflow
);
  localparam int OD = DIM - K + 1;
  localparam int D  = OD * OD;

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} state_t;

  state_t             state_q, state_d;
  logic [AW-1:0]      wr_count_q, wr_count_d;
  logic               overflow_q, overflow_d;
  logic               busy_q, busy_d;
  logic               frame_done_q, frame_done_d;
  logic               rd_valid_q, rd_valid_d;
  logic               rd_zero_q, rd_zero_d;
  logic               wr_en;
  logic               rd_in_range;
  logic signed [PP:0] wr_data;
  logic signed [PP:0] rd_ram_q;
  logic signed [PP:0] mem [D];

  assign rd_in_range = {1'b0, rd_addr} < (AW+1)'(D);

`ifdef CONV_COLLECT_RELU_EN
  assign wr_data = conv_in[PP] ? '0 : conv_in;
`else
  assign wr_data = conv_in;
`endif

  always_comb begin
    state_d    = state_q;
    wr_count_d = wr_count_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = CAPTURE;
          wr_count_d = '0;
          overflow_d = 1'b0;
        end else if (in_valid) begin
          overflow_d = 1'b1;
        end
      end
      CAPTURE: begin
        // A start here restarts the frame and drops this cycle's sample.
        if (start) begin
          wr_count_d = '0;
        end else if (in_valid) begin
          wr_en      = 1'b1;
          wr_count_d = wr_count_q + 1'b1;
          if (wr_count_q == AW'(D - 1)) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d       = (state_d == CAPTURE);
    frame_done_d = (state_d == DONE);
    rd_valid_d   = rd_en;
    rd_zero_d    = rd_en ? !rd_in_range : rd_zero_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_count_q   <= '0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_zero_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      wr_count_q   <= wr_count_d;
      overflow_q   <= overflow_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      rd_valid_q   <= rd_valid_d;
      rd_zero_q    <= rd_zero_d;
    end
  end

  // Unreset RAM port; a same-address read sees the value from before this write.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_count_q] <= wr_data;
    if (rd_en && rd_in_range) rd_ram_q <= mem[rd_addr];
  end

  assign rd_data    = rd_zero_q ? '0 : rd_ram_q;
  assign rd_valid   = rd_valid_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign wr_count   = wr_count_q;
  assign overflow   = overflow_q;
endmodule

// File: tb/tb_conv_collect.sv
// Self-checking bench for conv_collect against a queue-based frame model.
module tb_conv_collect;
  localparam int DIM = 32, K = 5, PP = 8, AW = 10;
  localparam int OD = DIM - K + 1;
  localparam int D  = OD * OD;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0, in_valid = 1'b0, rd_en = 1'b0;
  logic signed [PP:0] conv_in = '0;
  logic [AW-1:0] rd_addr = '0;
  logic signed [PP:0] rd_data;
  logic rd_valid, busy, frame_done, overflow;
  logic [AW-1:0] wr_count;

  always #5 clk = ~clk;

  conv_collect #(.DIM(DIM), .K(K), .PP(PP), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .conv_in(conv_in), .in_valid(in_valid),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .frame_done(frame_done), .wr_count(wr_count), .overflow(overflow)
  );

  // Reference model: the current frame is a queue of accepted samples.
  logic signed [PP:0] m_mem [D];
  bit m_known [D];
  int m_frame [$];
  bit m_capturing, m_done, m_ovf;
  logic signed [PP:0] e_rd_data;
  bit e_rd_valid, e_rd_known;
  int n_vec = 0, n_err = 0;

  function automatic logic signed [PP:0] stored(input logic signed [PP:0] v);
`ifdef CONV_COLLECT_RELU_EN
    return (v < 0) ? '0 : v;
`else
    return v;
`endif
  endfunction

  task automatic cycle(input bit st, input bit iv, input logic signed [PP:0] din,
                       input bit re, input int ra);
    start = st; in_valid = iv; conv_in = din; rd_en = re; rd_addr = AW'(ra);
    if (re) begin
      e_rd_valid = 1'b1;
      if (ra >= D) begin e_rd_data = '0; e_rd_known = 1'b1; end
      else begin e_rd_data = m_mem[ra]; e_rd_known = m_known[ra]; end
    end else begin
      e_rd_valid = 1'b0;
    end
    if (st) begin
      m_frame.delete(); m_capturing = 1'b1; m_done = 1'b0; m_ovf = 1'b0;
    end else if (iv && m_capturing) begin
      m_mem[m_frame.size()] = stored(din);
      m_known[m_frame.size()] = 1'b1;
      m_frame.push_back(int'(din));
      if (m_frame.size() == D) begin m_capturing = 1'b0; m_done = 1'b1; end
    end else if (iv) begin
      m_ovf = 1'b1;
    end
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b0; rd_en = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    m_frame.delete(); m_capturing = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
    e_rd_valid = 1'b0; e_rd_data = '0; e_rd_known = 1'b1;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_reset();
    #2; apply_reset();
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", frame_done); end
    n_vec++; if (wr_count !== '0) begin n_err++; $display("FAIL reset_count got %0d want 0", wr_count); end
    n_vec++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %b want 0", overflow); end
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rdv got %b want 0", rd_valid); end
    n_vec++; if (rd_data !== '0) begin n_err++; $display("FAIL reset_rdd got %0d want 0", rd_data); end
    release_reset();
    $display("reset: checked");
  endtask

  task automatic test_full_frame();
    cycle(1, 0, '0, 0, 0);
    n_vec++; if (busy !== 1'b1 || wr_count !== '0) begin n_err++;
      $display("FAIL ff_start got busy=%b cnt=%0d want busy=1 cnt=0", busy, wr_count); end
    for (int i = 0; i < D; i++) begin
      cycle(0, 1, (PP+1)'(i % 256), 0, 0);
      if (i == D - 2) begin
        n_vec++; if (frame_done !== 1'b0 || busy !== 1'b1) begin n_err++;
          $display("FAIL ff_early_done got done=%b busy=%b want 0/1", frame_done, busy); end
      end
    end
    n_vec++; if (frame_done !== 1'b1 || busy !== 1'b0) begin n_err++;
      $display("FAIL ff_done got done=%b busy=%b want 1/0", frame_done, busy); end
    n_vec++; if (wr_count !== AW'(784)) begin n_err++; $display("FAIL ff_count got %0d want 784", wr_count); end
    cycle(0, 0, '0, 1, 0);
    n_vec++; if (rd_valid !== 1'b1 || rd_data !== 9'sd0) begin n_err++;
      $display("FAIL ff_rd0 got v=%b d=%0d want 1/0", rd_valid, rd_data); end
    cycle(0, 0, '0, 1, 27);
    n_vec++; if (rd_valid !== 1'b1 || rd_data !== 9'sd27) begin n_err++;
      $display("FAIL ff_rd27 got v=%b d=%0d want 1/27", rd_valid, rd_data); end
    cycle(0, 0, '0, 1, 783);
    n_vec++; if (rd_valid !== 1'b1 || rd_data !== 9'sd15) begin n_err++;
      $display("FAIL ff_rd783 got v=%b d=%0d want 1/15", rd_valid, rd_data); end
    cycle(0, 0, '0, 0, 0);
    n_vec++; if (rd_valid !== 1'b0 || rd_data !== 9'sd15) begin n_err++;
      $display("FAIL ff_hold got v=%b d=%0d want 0/15", rd_valid, rd_data); end
    cycle(0, 1, 9'sd77, 0, 0);
    n_vec++; if (overflow !== 1'b1 || wr_count !== AW'(784)) begin n_err++;
      $display("FAIL ff_done_ovf got ovf=%b cnt=%0d want 1/784", overflow, wr_count); end
    $display("full_frame: checked");
  endtask

  task automatic test_overflow();
    apply_reset(); release_reset();
    cycle(0, 1, 9'sd5, 0, 0);
    n_vec++; if (overflow !== 1'b1 || wr_count !== '0) begin n_err++;
      $display("FAIL ovf_idle got ovf=%b cnt=%0d want 1/0", overflow, wr_count); end
    cycle(1, 0, '0, 0, 0);
    n_vec++; if (overflow !== 1'b0 || busy !== 1'b1) begin n_err++;
      $display("FAIL ovf_clear got ovf=%b busy=%b want 0/1", overflow, busy); end
    $display("overflow: checked");
  endtask

  task automatic test_start_with_sample();
    cycle(1, 1, 9'sd99, 0, 0);
    cycle(0, 1, 9'sd7, 0, 0);
    cycle(0, 1, 9'sd8, 0, 0);
    cycle(0, 1, 9'sd9, 0, 0);
    n_vec++; if (wr_count !== AW'(3)) begin n_err++; $display("FAIL sws_count got %0d want 3", wr_count); end
    cycle(0, 0, '0, 1, 0);
    n_vec++; if (rd_valid !== 1'b1 || rd_data !== 9'sd7) begin n_err++;
      $display("FAIL sws_rd0 got v=%b d=%0d want 1/7", rd_valid, rd_data); end
    // Back-to-back reads of 1, 2 and an out-of-range address.
    cycle(0, 0, '0, 1, 1);
    n_vec++; if (rd_valid !== 1'b1 || rd_data !== 9'sd8) begin n_err++;
      $display("FAIL b2b_rd1 got v=%b d=%0d want 1/8", rd_valid, rd_data); end
    cycle(0, 0, '0, 1, 2);
    n_vec++; if (rd_valid !== 1'b1 || rd_data !== 9'sd9) begin n_err++;
      $display("FAIL b2b_rd2 got v=%b d=%0d want 1/9", rd_valid, rd_data); end
    cycle(0, 0, '0, 1, 900);
    n_vec++; if (rd_valid !== 1'b1 || rd_data !== 9'sd0) begin n_err++;
      $display("FAIL b2b_rd900 got v=%b d=%0d want 1/0", rd_valid, rd_data); end
    cycle(0, 0, '0, 0, 0);
    n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end got v=%b want 0", rd_valid); end
    // Address 3 still holds 3 from the earlier full frame; read and write it together.
    cycle(0, 1, 9'sd42, 1, 3);
    n_vec++; if (rd_data !== 9'sd3) begin n_err++; $display("FAIL rw_old got %0d want 3", rd_data); end
    cycle(0, 0, '0, 1, 3);
    n_vec++; if (rd_data !== 9'sd42) begin n_err++; $display("FAIL rw_new got %0d want 42", rd_data); end
    $display("start_with_sample: checked");
  endtask

  task automatic test_sign();
    logic signed [PP:0] want;
`ifdef CONV_COLLECT_RELU_EN
    want = 9'sd0;
`else
    want = 9'h1FD;
`endif
    cycle(1, 0, '0, 0, 0);
    cycle(0, 1, -9'sd3, 0, 0);
    cycle(0, 0, '0, 1, 0);
    n_vec++; if (rd_data !== want) begin n_err++; $display("FAIL sign got %h want %h", rd_data, want); end
    $display("sign: checked");
  endtask

  task automatic test_reset_mid();
    cycle(1, 0, '0, 0, 0);
    for (int i = 0; i < 100; i++) cycle(0, 1, (PP+1)'($urandom), 0, 0);
    n_vec++; if (wr_count !== AW'(100)) begin n_err++; $display("FAIL mid_count got %0d want 100", wr_count); end
    cycle(0, 0, '0, 1, 5);
    apply_reset();
    n_vec++; if ({busy, frame_done, overflow, rd_valid} !== 4'b0 || wr_count !== '0 || rd_data !== '0) begin
      n_err++; $display("FAIL mid_reset got busy=%b done=%b ovf=%b rdv=%b cnt=%0d rdd=%0d want all 0",
                        busy, frame_done, overflow, rd_valid, wr_count, rd_data); end
    release_reset();
    cycle(1, 0, '0, 0, 0);
    for (int i = 0; i < D; i++) cycle(0, 1, (PP+1)'($urandom), 0, 0);
    n_vec++; if (frame_done !== 1'b1 || wr_count !== AW'(D)) begin n_err++;
      $display("FAIL mid_refill got done=%b cnt=%0d want 1/%0d", frame_done, wr_count, D); end
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, '0, 1, $urandom_range(0, D - 1));
      n_vec++; if (rd_data !== e_rd_data) begin n_err++;
        $display("FAIL mid_rd got %0d want %0d", rd_data, e_rd_data); end
    end
    $display("reset_mid: checked");
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      bit st, iv, re;
      st = (i == 0) || ($urandom_range(0, 1499) == 0);
      iv = ($urandom_range(0, 9) < 7);
      re = $urandom_range(0, 1);
      cycle(st, iv, (PP+1)'($urandom), re, $urandom_range(0, 1023));
      n_vec++; if (wr_count !== AW'(m_frame.size())) begin n_err++;
        $display("FAIL rnd_count cyc %0d got %0d want %0d", i, wr_count, m_frame.size()); end
      n_vec++; if (busy !== m_capturing || frame_done !== m_done || overflow !== m_ovf) begin n_err++;
        $display("FAIL rnd_flags cyc %0d got b=%b d=%b o=%b want %b/%b/%b", i, busy, frame_done,
                 overflow, m_capturing, m_done, m_ovf); end
      n_vec++; if (rd_valid !== e_rd_valid) begin n_err++;
        $display("FAIL rnd_rdv cyc %0d got %b want %b", i, rd_valid, e_rd_valid); end
      if (e_rd_known) begin
        n_vec++; if (rd_data !== e_rd_data) begin n_err++;
          $display("FAIL rnd_rdd cyc %0d got %0d want %0d", i, rd_data, e_rd_data); end
      end
    end
    $display("random: checked");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_overflow();
    test_start_with_sample();
    test_sign();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
